// File: rtl/prim_sparse_fsm_chk_flop.sv
// prim_sparse_fsm_chk_flop
//
// Hardened state register for sparse-encoded FSMs. It replaces a plain state
// flop: the FSM's next-state logic drives state_i and the FSM reads state_o.
// Around the state register it adds:
//   - a legal-encoding check on every commit,
//   - an inverted shadow copy compared every cycle (optional),
//   - a dwell-time watchdog for non-exempt states (optional),
//   - a saturating transition counter.
// Any detected fault forces the register into ErrorState, sets a sticky
// error flag with sticky cause bits, and pulses alert_o for one cycle. Only
// reset leaves the fault mode.
//
// Ports
//   clk_i        in   1     clock
//   rst_i        in   1     asynchronous active-high reset
//   en_i         in   1     commit state_i at this edge
//   state_i      in   W     next state from the FSM
//   state_o      out  W     registered state (reset: ResetState)
//   err_o        out  1     sticky error flag
//   err_cause_o  out  3     sticky causes {dwell, mismatch, illegal}
//   alert_o      out  1     one-cycle pulse on entry into fault mode
//   trans_cnt_o  out  CntW  saturating count of state changes

module prim_sparse_fsm_chk_flop #(
  parameter type                      StateEnumT   = logic [8:0],
  parameter int                       NumLegal     = 4,
  parameter StateEnumT [NumLegal-1:0] LegalStates  = '0,
  parameter StateEnumT                ResetState   = '0,
  parameter StateEnumT                ErrorState   = '1,
  parameter bit                       EnableShadow = 1'b1,
  parameter int                       MaxDwell     = 0,
  parameter int                       CntW         = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  StateEnumT        state_i,
  output StateEnumT        state_o,
  output logic             err_o,
  output logic [2:0]       err_cause_o,
  output logic             alert_o,
  output logic [CntW-1:0]  trans_cnt_o
);

  localparam int W = $bits(StateEnumT);

  // The dwell counter only needs to reach MaxDwell; keep one bit when the
  // watchdog is disabled so the declarations stay legal.
  localparam int DwW = (MaxDwell > 0) ? $clog2(MaxDwell + 1) : 1;
  localparam logic [DwW-1:0] DwellMax  = (MaxDwell > 0) ? DwW'(MaxDwell) : '0;
  localparam logic [DwW-1:0] DwellLast = (MaxDwell > 0) ? DwW'(MaxDwell - 1) : '0;
  localparam logic [CntW-1:0] CntSat   = {CntW{1'b1}};

  // An encoding is legal if it is one of the listed states or the error state.
  function automatic logic is_legal(input logic [W-1:0] s);
    logic hit;
    hit = (s == ErrorState);
    for (int i = 0; i < NumLegal; i++) begin
      hit = hit | (s == LegalStates[i]);
    end
    return hit;
  endfunction

  // Registers
  StateEnumT        state_r;
  logic [DwW-1:0]   dwell_r;
  logic [CntW-1:0]  cnt_r;
  logic             err_r;     // 0 = RUN, 1 = FAULT
  logic [2:0]       cause_r;
  logic             alert_r;

  // Combinational helpers
  StateEnumT        state_nxt_s;
  logic             chg_commit_s;
  logic             illegal_s;
  logic             mismatch_s;
  logic             dwell_s;
  logic [2:0]       cause_new_s;
  logic             any_err_s;
  logic [DwW-1:0]   dwell_inc_s;

  // Error-source evaluation; in FAULT en_i is ignored, so only mismatch can add causes.
  always_comb begin
    chg_commit_s = en_i && (state_i != state_r);

    if (!err_r) begin
      illegal_s = en_i && !is_legal(state_i);
    end else begin
      illegal_s = 1'b0;
    end

    if ((MaxDwell != 0) && !err_r) begin
      dwell_s = (state_r != ResetState) && (state_r != ErrorState) &&
                !chg_commit_s && (dwell_r == DwellLast);
    end else begin
      dwell_s = 1'b0;
    end

    cause_new_s = {dwell_s, mismatch_s, illegal_s};
    any_err_s   = |cause_new_s;
  end

  // Saturating increment of the dwell counter (stays 0 when the watchdog is off).
  always_comb begin
    if (dwell_r >= DwellMax) begin
      dwell_inc_s = DwellMax;
    end else begin
      dwell_inc_s = dwell_r + DwW'(1);
    end
  end

  // Next value of the state register; shared with the shadow copy so both move in lockstep.
  always_comb begin
    state_nxt_s = state_r;
    if (err_r || any_err_s) begin
      state_nxt_s = ErrorState;
    end else if (en_i) begin
      state_nxt_s = state_i;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, mode, cause, alert, dwell and transition-counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ResetState;
      dwell_r <= '0;
      cnt_r   <= '0;
      err_r   <= 1'b0;
      cause_r <= 3'b000;
      alert_r <= 1'b0;
    end else if (err_r) begin
      // FAULT: parked in ErrorState, counters frozen, causes stay sticky.
      state_r <= state_nxt_s;
      cause_r <= cause_r | cause_new_s;
      alert_r <= 1'b0;
    end else if (any_err_s) begin
      // RUN -> FAULT: the offending state_i is dropped.
      state_r <= state_nxt_s;
      err_r   <= 1'b1;
      alert_r <= 1'b1;
      cause_r <= cause_r | cause_new_s;
    end else if (en_i) begin
      state_r <= state_nxt_s;
      alert_r <= 1'b0;
      if (chg_commit_s) begin
        dwell_r <= '0;
        if (cnt_r != CntSat) begin
          cnt_r <= cnt_r + CntW'(1);
        end else begin
          cnt_r <= cnt_r;
        end
      end else begin
        dwell_r <= dwell_inc_s;
      end
    end else begin
      alert_r <= 1'b0;
      dwell_r <= dwell_inc_s;
    end
  end

  if (EnableShadow) begin : g_shadow
    logic [W-1:0] shadow_r;

    // Inverted shadow copy of the state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        shadow_r <= ~ResetState;
      end else begin
        shadow_r <= ~state_nxt_s;
      end
    end

    // A corrupted state flop shows up either as disagreement with the
    // shadow or as an encoding that no legal commit could have produced.
    assign mismatch_s = (state_r != ~shadow_r) || !is_legal(state_r);
  end else begin : g_no_shadow
    assign mismatch_s = 1'b0;
  end

  assign state_o     = state_r;
  assign err_o       = err_r;
  assign err_cause_o = cause_r;
  assign alert_o     = alert_r;
  assign trans_cnt_o = cnt_r;

endmodule

// File: tb/tb_prim_sparse_fsm_chk_flop.sv
// Directed bench for prim_sparse_fsm_chk_flop with a 6-bit sparse encoding.
module tb_prim_sparse_fsm_chk_flop;

  localparam logic [5:0] S_RST = 6'h15;
  localparam logic [5:0] S_A   = 6'h2A;
  localparam logic [5:0] S_B   = 6'h0F;
  localparam logic [5:0] S_ERR = 6'h3C;
  localparam logic [5:0] S_BAD = 6'h01;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [5:0] state_in;
  logic [5:0] state_out;
  logic       err;
  logic [2:0] cause;
  logic       alert;
  logic [3:0] cnt;

  int n_assert = 0;
  int n_fail   = 0;

  prim_sparse_fsm_chk_flop #(
    .StateEnumT   (logic [5:0]),
    .NumLegal     (3),
    .LegalStates  ({6'h0F, 6'h2A, 6'h15}),
    .ResetState   (6'h15),
    .ErrorState   (6'h3C),
    .EnableShadow (1'b1),
    .MaxDwell     (4),
    .CntW         (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .state_i     (state_in),
    .state_o     (state_out),
    .err_o       (err),
    .err_cause_o (cause),
    .alert_o     (alert),
    .trans_cnt_o (cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One commit across a single rising edge; returns at the following falling edge.
  task automatic commit(input logic [5:0] s);
    @(negedge clk);
    en       = 1'b1;
    state_in = s;
    @(negedge clk);
    en       = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, state_out, S_RST);
    check({tag, "_err"},   err,       1'b0);
    check({tag, "_cause"}, cause,     3'b000);
    check({tag, "_alert"}, alert,     1'b0);
    check({tag, "_cnt"},   cnt,       4'h0);
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    state_in = 6'h00;
    #12;
    check_reset_vals("rst");
    @(negedge clk);
    rst = 1'b0;

    // Reset and ordinary commits
    commit(S_A);
    check("c1_state", state_out, S_A);
    check("c1_cnt",   cnt,       4'h1);
    commit(S_B);
    check("c2_state", state_out, S_B);
    check("c2_cnt",   cnt,       4'h2);
    check("c2_err",   err,       1'b0);
    // FSM may enter ErrorState on its own without raising an error
    commit(S_ERR);
    check("c3_state", state_out, S_ERR);
    check("c3_cnt",   cnt,       4'h3);
    check("c3_err",   err,       1'b0);
    idle(6);
    check("c3_hold_err", err, 1'b0);
    commit(S_A);
    check("c4_cnt", cnt, 4'h4);

    // Illegal commit
    commit(S_BAD);
    check("ill_state", state_out, S_ERR);
    check("ill_err",   err,       1'b1);
    check("ill_cause", cause,     3'b001);
    check("ill_alert", alert,     1'b1);
    idle(1);
    check("ill_alert_drop", alert, 1'b0);
    commit(S_B);
    check("ill_ignore_state", state_out, S_ERR);
    check("ill_ignore_cnt",   cnt,       4'h4);
    check("ill_sticky_err",   err,       1'b1);

    // Shadow corruption
    do_reset();
    check_reset_vals("rst2");
    commit(S_A);
    check("sh_pre_state", state_out, S_A);
    force dut.g_shadow.shadow_r = 6'h14;
    @(posedge clk);
    #1;
    release dut.g_shadow.shadow_r;
    @(negedge clk);
    check("sh_state", state_out, S_ERR);
    check("sh_cause", cause,     3'b010);
    check("sh_alert", alert,     1'b1);
    idle(2);
    check("sh_cause_hold", cause, 3'b010);
    check("sh_alert_drop", alert, 1'b0);

    // Dwell watchdog
    do_reset();
    commit(S_A);
    idle(3);
    check("dw_early_err",   err,       1'b0);
    check("dw_early_state", state_out, S_A);
    idle(1);
    check("dw_err",   err,       1'b1);
    check("dw_state", state_out, S_ERR);
    check("dw_cause", cause,     3'b100);
    check("dw_alert", alert,     1'b1);

    // Reset state is exempt from the watchdog
    do_reset();
    idle(20);
    check("dw_rst_err",   err,       1'b0);
    check("dw_rst_state", state_out, S_RST);

    // Counter saturation
    do_reset();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      en       = 1'b1;
      state_in = (i % 2 == 1) ? S_B : S_A;
    end
    @(negedge clk);
    en = 1'b0;
    check("sat15_cnt",   cnt,       4'hF);
    check("sat15_state", state_out, S_A);
    for (int i = 15; i < 20; i++) begin
      @(negedge clk);
      en       = 1'b1;
      state_in = (i % 2 == 1) ? S_B : S_A;
    end
    @(negedge clk);
    en = 1'b0;
    check("sat20_cnt",   cnt,       4'hF);
    check("sat20_state", state_out, S_B);
    check("sat20_err",   err,       1'b0);

    // Illegal input, then asynchronous reset in the middle of a cycle
    commit(S_BAD);
    check("mid_err",   err,   1'b1);
    check("mid_cause", cause, 3'b001);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("async");
    #1;
    rst = 1'b0;
    commit(S_B);
    check("post_state", state_out, S_B);
    check("post_cnt",   cnt,       4'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
